pad_gpio_ctrl: RTL and testbench

Per-pin GPIO controller that sits directly upstream of the bidirectional functional pad cells. It drives each pad's OEN, I, PEN and PUEN pins from registered configuration, and consumes the pad's O pin. On the input side it provides synchronisation, optional debouncing, rise/fall edge detection and a sticky interrupt per pin. The SoC GPIO register file sits above it and provides static configuration plus clear pulses.

---
 rtl/pad_gpio_ctrl.sv | 149 ++++++++++++++
 tb/tb_pad_gpio_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_gpio_ctrl.sv
// Per-pin GPIO controller driving bidirectional pad cells: registered pad control on the way out,
// synchroniser, optional debounce filter, edge detect and sticky interrupts on the way in.
module pad_gpio_ctrl #(
    parameter int unsigned NrPads         = 8,
    parameter int unsigned SyncStages     = 2,
    parameter int unsigned DebounceCycles = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NrPads-1:0] dir_i,
    input  logic [NrPads-1:0] out_i,
    input  logic [NrPads-1:0] pull_en_i,
    input  logic [NrPads-1:0] pull_up_i,
    input  logic [NrPads-1:0] deb_en_i,
    input  logic [NrPads-1:0] irq_rise_en_i,
    input  logic [NrPads-1:0] irq_fall_en_i,
    input  logic [NrPads-1:0] irq_clr_i,
    input  logic [NrPads-1:0] pad_o_i,
    output logic [NrPads-1:0] pad_oen_o,
    output logic [NrPads-1:0] pad_i_o,
    output logic [NrPads-1:0] pad_pen_o,
    output logic [NrPads-1:0] pad_puen_o,
    output logic [NrPads-1:0] in_o,
    output logic [NrPads-1:0] irq_pending_o,
    output logic              irq_o
);

    localparam int unsigned     CntW   = $clog2(DebounceCycles) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

    if (SyncStages < 2) begin : gen_sync_stages_check
        $error("pad_gpio_ctrl: SyncStages must be >= 2");
    end
    if (DebounceCycles < 1) begin : gen_debounce_check
        $error("pad_gpio_ctrl: DebounceCycles must be >= 1");
    end

    // ------------------------------------------------------------------------
    // Pad drive path
    // ------------------------------------------------------------------------
    logic [NrPads-1:0] oen_q;
    logic [NrPads-1:0] drv_q;
    logic [NrPads-1:0] pen_q;
    logic [NrPads-1:0] puen_q;

    // Reset values leave drivers and pulls disabled so the pads float safely.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            oen_q  <= '1;
            drv_q  <= '0;
            pen_q  <= '1;
            puen_q <= '1;
        end else begin
            oen_q  <= ~dir_i;
            drv_q  <= out_i & dir_i;
            pen_q  <= ~pull_en_i;
            puen_q <= ~(pull_up_i & pull_en_i);
        end
    end

    assign pad_oen_o  = oen_q;
    assign pad_i_o    = drv_q;
    assign pad_pen_o  = pen_q;
    assign pad_puen_o = puen_q;

    // ------------------------------------------------------------------------
    // Input synchroniser; runs regardless of direction so outputs loop back
    // ------------------------------------------------------------------------
    logic [SyncStages-1:0][NrPads-1:0] sync_q;
    logic [NrPads-1:0]                 sync;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], pad_o_i};
        end
    end

    assign sync = sync_q[SyncStages-1];

    // ------------------------------------------------------------------------
    // Debounce filter
    // ------------------------------------------------------------------------
    logic [NrPads-1:0]           in_q;
    logic [NrPads-1:0]           in_d;
    logic [NrPads-1:0][CntW-1:0] cnt_q;
    logic [NrPads-1:0][CntW-1:0] cnt_d;

    // A pin only follows sync after DebounceCycles consecutive mismatching cycles.
    always_comb begin
        in_d  = in_q;
        cnt_d = cnt_q;
        for (int p = 0; p < NrPads; p++) begin
            if (!deb_en_i[p]) begin
                in_d[p]  = sync[p];
                cnt_d[p] = '0;
            end else if (sync[p] == in_q[p]) begin
                cnt_d[p] = '0;
            end else if (cnt_q[p] == CntMax) begin
                in_d[p]  = sync[p];
                cnt_d[p] = '0;
            end else begin
                cnt_d[p] = cnt_q[p] + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_q  <= '0;
            cnt_q <= '0;
        end else begin
            in_q  <= in_d;
            cnt_q <= cnt_d;
        end
    end

    assign in_o = in_q;

    // ------------------------------------------------------------------------
    // Edge detection and sticky interrupts
    // ------------------------------------------------------------------------
    logic [NrPads-1:0] rise;
    logic [NrPads-1:0] fall;
    logic [NrPads-1:0] irq_set;
    logic [NrPads-1:0] pend_q;
    logic [NrPads-1:0] pend_d;

    // Set has priority over a coincident clear so no edge is lost.
    always_comb begin
        rise    = in_d & ~in_q;
        fall    = ~in_d & in_q;
        irq_set = (rise & irq_rise_en_i) | (fall & irq_fall_en_i);
        pend_d  = irq_set | (pend_q & ~irq_clr_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign irq_pending_o = pend_q;
    assign irq_o         = |pend_q;

endmodule

// File: tb/tb_pad_gpio_ctrl.sv
// Self-checking bench for pad_gpio_ctrl: expectations are queued when stimulus is applied and
// popped when the corresponding DUT output is sampled.
module tb_pad_gpio_ctrl;

    localparam int unsigned NrPads = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NrPads-1:0] dir, out_v, pull_en, pull_up, deb_en;
    logic [NrPads-1:0] rise_en, fall_en, irq_clr, pad_o;
    logic [NrPads-1:0] pad_oen, pad_i, pad_pen, pad_puen, in_v, pend;
    logic              irq;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [7:0]  sb[$];
    logic [7:0]  exp;

    pad_gpio_ctrl #(
        .NrPads         (NrPads),
        .SyncStages     (2),
        .DebounceCycles (4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .dir_i         (dir),
        .out_i         (out_v),
        .pull_en_i     (pull_en),
        .pull_up_i     (pull_up),
        .deb_en_i      (deb_en),
        .irq_rise_en_i (rise_en),
        .irq_fall_en_i (fall_en),
        .irq_clr_i     (irq_clr),
        .pad_o_i       (pad_o),
        .pad_oen_o     (pad_oen),
        .pad_i_o       (pad_i),
        .pad_pen_o     (pad_pen),
        .pad_puen_o    (pad_puen),
        .in_o          (in_v),
        .irq_pending_o (pend),
        .irq_o         (irq)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        dir = 8'($urandom); out_v = 8'($urandom); pull_en = 8'($urandom);
        pull_up = 8'($urandom); deb_en = 8'($urandom); rise_en = 8'($urandom);
        fall_en = 8'($urandom); irq_clr = 8'($urandom); pad_o = 8'($urandom);
        for (int k = 0; k < 2; k++) begin
            sb.push_back(8'hFF); sb.push_back(8'hFF); sb.push_back(8'h00);
            sb.push_back(8'h00); sb.push_back(8'h00);
        end
        #12;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                @(posedge clk); #1;
                rst_n = 1'b1;
                #1;
            end
            exp = sb.pop_front(); vectors++;
            if (pad_oen !== exp) begin
                miscompares++; $display("FAIL reset_oen[%0d]: got %h want %h", k, pad_oen, exp);
            end
            exp = sb.pop_front(); vectors++;
            if (pad_pen !== exp) begin
                miscompares++; $display("FAIL reset_pen[%0d]: got %h want %h", k, pad_pen, exp);
            end
            exp = sb.pop_front(); vectors++;
            if (pad_i !== exp) begin
                miscompares++; $display("FAIL reset_i[%0d]: got %h want %h", k, pad_i, exp);
            end
            exp = sb.pop_front(); vectors++;
            if (in_v !== exp) begin
                miscompares++; $display("FAIL reset_in[%0d]: got %h want %h", k, in_v, exp);
            end
            exp = sb.pop_front(); vectors++;
            if (irq !== exp[0]) begin
                miscompares++; $display("FAIL reset_irq[%0d]: got %b want %b", k, irq, exp[0]);
            end
        end
        dir = '0; out_v = '0; pull_en = '0; pull_up = '0; deb_en = '0;
        rise_en = '0; fall_en = '0; irq_clr = '0; pad_o = '0;
        step(4);
    endtask

    task automatic test_drive();
        dir = 8'h01; out_v = 8'h01; pull_en = 8'h02; pull_up = 8'h02;
        sb.push_back(8'hFE); sb.push_back(8'h01); sb.push_back(8'hFD); sb.push_back(8'hFD);
        step(1);
        exp = sb.pop_front(); vectors++;
        if (pad_oen !== exp) begin
            miscompares++; $display("FAIL drive_oen: got %h want %h", pad_oen, exp);
        end
        exp = sb.pop_front(); vectors++;
        if (pad_i !== exp) begin
            miscompares++; $display("FAIL drive_i: got %h want %h", pad_i, exp);
        end
        exp = sb.pop_front(); vectors++;
        if (pad_pen !== exp) begin
            miscompares++; $display("FAIL drive_pen: got %h want %h", pad_pen, exp);
        end
        exp = sb.pop_front(); vectors++;
        if (pad_puen !== exp) begin
            miscompares++; $display("FAIL drive_puen: got %h want %h", pad_puen, exp);
        end
    endtask

    task automatic test_passthrough();
        rise_en = 8'h08;
        pad_o[3] = 1'b1;
        sb.push_back(8'h00); sb.push_back(8'h00);
        sb.push_back(8'h01); sb.push_back(8'h01); sb.push_back(8'h01);
        step(2);
        exp = sb.pop_front(); vectors++;
        if (in_v[3] !== exp[0]) begin
            miscompares++; $display("FAIL pass_in3_early: got %b want %b", in_v[3], exp[0]);
        end
        exp = sb.pop_front(); vectors++;
        if (pend[3] !== exp[0]) begin
            miscompares++; $display("FAIL pass_pend3_early: got %b want %b", pend[3], exp[0]);
        end
        step(1);
        exp = sb.pop_front(); vectors++;
        if (in_v[3] !== exp[0]) begin
            miscompares++; $display("FAIL pass_in3: got %b want %b", in_v[3], exp[0]);
        end
        exp = sb.pop_front(); vectors++;
        if (pend[3] !== exp[0]) begin
            miscompares++; $display("FAIL pass_pend3: got %b want %b", pend[3], exp[0]);
        end
        exp = sb.pop_front(); vectors++;
        if (irq !== exp[0]) begin
            miscompares++; $display("FAIL pass_irq: got %b want %b", irq, exp[0]);
        end
    endtask

    task automatic test_debounce();
        deb_en = 8'h20;
        step(1);
        pad_o[5] = 1'b1;
        for (int c = 0; c < 9; c++) begin
            sb.push_back(8'h00);
            step(1);
            if (c == 2) pad_o[5] = 1'b0;
            exp = sb.pop_front(); vectors++;
            if (in_v[5] !== exp[0]) begin
                miscompares++; $display("FAIL deb_glitch_c%0d: got %b want %b", c, in_v[5], exp[0]);
            end
        end
        pad_o[5] = 1'b1;
        sb.push_back(8'h00); sb.push_back(8'h01); sb.push_back(8'h00);
        step(5);
        exp = sb.pop_front(); vectors++;
        if (in_v[5] !== exp[0]) begin
            miscompares++; $display("FAIL deb_stable_t5: got %b want %b", in_v[5], exp[0]);
        end
        step(1);
        exp = sb.pop_front(); vectors++;
        if (in_v[5] !== exp[0]) begin
            miscompares++; $display("FAIL deb_stable_t6: got %b want %b", in_v[5], exp[0]);
        end
        exp = sb.pop_front(); vectors++;
        if (pend[5] !== exp[0]) begin
            miscompares++; $display("FAIL deb_pend5_disabled: got %b want %b", pend[5], exp[0]);
        end
    endtask

    task automatic test_clr_collision();
        irq_clr = '1;
        sb.push_back(8'h00); sb.push_back(8'h00);
        step(1);
        irq_clr = '0;
        exp = sb.pop_front(); vectors++;
        if (pend !== exp) begin
            miscompares++; $display("FAIL clr_all: got %h want %h", pend, exp);
        end
        exp = sb.pop_front(); vectors++;
        if (irq !== exp[0]) begin
            miscompares++; $display("FAIL clr_all_irq: got %b want %b", irq, exp[0]);
        end
        rise_en = 8'h0C; fall_en = 8'h04;
        pad_o[2] = 1'b1;
        sb.push_back(8'h01); sb.push_back(8'h00);
        step(3);
        exp = sb.pop_front(); vectors++;
        if (pend[2] !== exp[0]) begin
            miscompares++; $display("FAIL coll_rise_pend2: got %b want %b", pend[2], exp[0]);
        end
        irq_clr[2] = 1'b1;
        step(1);
        irq_clr[2] = 1'b0;
        exp = sb.pop_front(); vectors++;
        if (pend[2] !== exp[0]) begin
            miscompares++; $display("FAIL coll_first_clear: got %b want %b", pend[2], exp[0]);
        end
        pad_o[2] = 1'b0;
        sb.push_back(8'h00); sb.push_back(8'h01);
        step(2);
        irq_clr[2] = 1'b1;
        step(1);
        irq_clr[2] = 1'b0;
        exp = sb.pop_front(); vectors++;
        if (in_v[2] !== exp[0]) begin
            miscompares++; $display("FAIL coll_in2_fell: got %b want %b", in_v[2], exp[0]);
        end
        exp = sb.pop_front(); vectors++;
        if (pend[2] !== exp[0]) begin
            miscompares++; $display("FAIL coll_set_wins: got %b want %b", pend[2], exp[0]);
        end
        sb.push_back(8'h00); sb.push_back(8'h00);
        irq_clr[2] = 1'b1;
        step(1);
        irq_clr[2] = 1'b0;
        exp = sb.pop_front(); vectors++;
        if (pend[2] !== exp[0]) begin
            miscompares++; $display("FAIL coll_lone_clear: got %b want %b", pend[2], exp[0]);
        end
        exp = sb.pop_front(); vectors++;
        if (irq !== exp[0]) begin
            miscompares++; $display("FAIL coll_irq_low: got %b want %b", irq, exp[0]);
        end
    endtask

    task automatic test_reset_mid_debounce();
        fall_en = 8'h0C;
        pad_o[5] = 1'b0;
        pad_o[3] = 1'b0;
        sb.push_back(8'h01); sb.push_back(8'h01); sb.push_back(8'h01);
        step(3);
        exp = sb.pop_front(); vectors++;
        if (pend[3] !== exp[0]) begin
            miscompares++; $display("FAIL mid_pend3_set: got %b want %b", pend[3], exp[0]);
        end
        exp = sb.pop_front(); vectors++;
        if (in_v[5] !== exp[0]) begin
            miscompares++; $display("FAIL mid_in5_hold_a: got %b want %b", in_v[5], exp[0]);
        end
        step(1);
        exp = sb.pop_front(); vectors++;
        if (in_v[5] !== exp[0]) begin
            miscompares++; $display("FAIL mid_in5_hold_b: got %b want %b", in_v[5], exp[0]);
        end
        rst_n = 1'b0;
        sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'h00);
        #1;
        exp = sb.pop_front(); vectors++;
        if (pend !== exp) begin
            miscompares++; $display("FAIL mid_rst_pend: got %h want %h", pend, exp);
        end
        exp = sb.pop_front(); vectors++;
        if (irq !== exp[0]) begin
            miscompares++; $display("FAIL mid_rst_irq: got %b want %b", irq, exp[0]);
        end
        exp = sb.pop_front(); vectors++;
        if (in_v !== exp) begin
            miscompares++; $display("FAIL mid_rst_in: got %h want %h", in_v, exp);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        pad_o[5] = 1'b1;
        sb.push_back(8'h00); sb.push_back(8'h01); sb.push_back(8'h00);
        step(5);
        exp = sb.pop_front(); vectors++;
        if (in_v[5] !== exp[0]) begin
            miscompares++; $display("FAIL mid_refill_t5: got %b want %b", in_v[5], exp[0]);
        end
        step(1);
        exp = sb.pop_front(); vectors++;
        if (in_v[5] !== exp[0]) begin
            miscompares++; $display("FAIL mid_refill_t6: got %b want %b", in_v[5], exp[0]);
        end
        exp = sb.pop_front(); vectors++;
        if (pend !== exp) begin
            miscompares++; $display("FAIL mid_pend_after: got %h want %h", pend, exp);
        end
    endtask

    initial begin
        test_reset();
        test_drive();
        test_passthrough();
        test_debounce();
        test_clr_collision();
        test_reset_mid_debounce();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
